fi_injector: RTL and testbench

Fault-injection controller that forces faults onto a bus of signals of interest (SoI) under command control. It sits between a DUT's internal state signals and their consumers, passing `sig_in` through to `sig_out` unchanged except during a programmed injection window. It is the write-side counterpart of the SoI value-reporting path: a testbench or DPI-driven host issues a command, and the block applies stuck-at-0, stuck-at-1 or bit-flip faults after a delay for a programmed number of cycles.

---
 rtl/fi_injector.sv | 129 ++++++++++++
 tb/tb_fi_injector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fi_injector.sv
// Fault-injection controller. It passes sig_in to sig_out and, once a command is accepted,
// forces stuck-at or bit-flip faults onto the masked bits for a delayed, bounded window.
module fi_injector #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_delay,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             abort,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic             inject_active,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] inj_count
);

    typedef enum logic [1:0] {IDLE, WAIT, INJECT, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] mask_q, mask_next;
    logic [1:0]       mode_q, mode_next;
    logic [CNT_W-1:0] len_q, len_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask_q    <= '0;
            mode_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err       <= 1'b0;
            inj_count <= '0;
        end else begin
            state  <= next_state;
            mask_q <= mask_next;
            mode_q <= mode_next;
            len_q  <= len_next;
            cnt_q  <= cnt_next;
            err    <= err_next;
            if (state == DONE && !abort && inj_count != {CNT_W{1'b1}})
                inj_count <= inj_count + CNT_W'(1);
        end
    end

    // The counter always terminates at 1, so a full-scale delay or len never wraps.
    always_comb begin
        next_state = state;
        mask_next  = mask_q;
        mode_next  = mode_q;
        len_next   = len_q;
        cnt_next   = cnt_q;
        err_next   = 1'b0;
        if (abort) begin
            next_state = IDLE;
            mask_next  = '0;
            mode_next  = '0;
            len_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_mode == 2'b11) begin
                            err_next = 1'b1;
                        end else begin
                            mask_next = cmd_mask;
                            mode_next = cmd_mode;
                            len_next  = cmd_len;
                            if (cmd_delay == '0) begin
                                next_state = INJECT;
                                cnt_next   = cmd_len;
                            end else begin
                                next_state = WAIT;
                                cnt_next   = cmd_delay;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        next_state = INJECT;
                        cnt_next   = len_q;
                    end else begin
                        cnt_next = cnt_q - CNT_W'(1);
                    end
                end
                INJECT: begin
                    if (len_q != '0) begin
                        if (cnt_q == CNT_W'(1)) begin
                            next_state = DONE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_q - CNT_W'(1);
                        end
                    end
                end
                DONE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Zero-latency fault overlay; exact passthrough outside the window.
    always_comb begin
        sig_out = sig_in;
        if (state == INJECT) begin
            case (mode_q)
                2'b00:   sig_out = sig_in & ~mask_q;
                2'b01:   sig_out = sig_in | mask_q;
                2'b10:   sig_out = sig_in ^ mask_q;
                default: sig_out = sig_in;
            endcase
        end
    end

    assign cmd_ready     = (state == IDLE) && !abort;
    assign inject_active = (state == INJECT);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_fi_injector.sv
// Directed bench for fi_injector: a vector table for the main timing paths plus
// hand-written sequences for unbounded windows, reset in WAIT and count saturation.
module tb_fi_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, abort;
    logic [2:0]  cmd_mask, sig_in, sig_out;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_delay, cmd_len, inj_count;
    logic        inject_active, done, err;

    logic        s_reset;
    logic        s_valid, s_ready, s_abort;
    logic [2:0]  s_mask, s_in, s_out;
    logic [1:0]  s_mode;
    logic [1:0]  s_delay, s_len, s_count;
    logic        s_active, s_done, s_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  mask;
        logic [1:0]  mode;
        logic [15:0] delay;
        logic [15:0] len;
        logic        abort;
        logic [2:0]  sin;
        logic [2:0]  eout;
        logic        erdy;
        logic        eact;
        logic        edone;
        logic        eerr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fi_injector #(.WIDTH(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mask(cmd_mask), .cmd_mode(cmd_mode), .cmd_delay(cmd_delay), .cmd_len(cmd_len),
        .abort(abort), .sig_in(sig_in), .sig_out(sig_out), .inject_active(inject_active),
        .done(done), .err(err), .inj_count(inj_count)
    );

    fi_injector #(.WIDTH(3), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(s_reset), .cmd_valid(s_valid), .cmd_ready(s_ready),
        .cmd_mask(s_mask), .cmd_mode(s_mode), .cmd_delay(s_delay), .cmd_len(s_len),
        .abort(s_abort), .sig_in(s_in), .sig_out(s_out), .inject_active(s_active),
        .done(s_done), .err(s_err), .inj_count(s_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
        end
    endtask

    task automatic addRow(input logic v, input logic [2:0] m, input logic [1:0] md,
                          input logic [15:0] d, input logic [15:0] l, input logic ab,
                          input logic [2:0] si, input logic [2:0] eo, input logic er,
                          input logic ea, input logic ed, input logic ee, input logic [15:0] ec);
        vec_t r;
        r.valid = v;  r.mask = m;   r.mode = md; r.delay = d;  r.len = l;
        r.abort = ab; r.sin = si;   r.eout = eo; r.erdy = er;  r.eact = ea;
        r.edone = ed; r.eerr = ee;  r.ecnt = ec;
        vecs.push_back(r);
    endtask

    task automatic applyStimulus(input vec_t r);
        cmd_valid = r.valid;
        cmd_mask  = r.mask;
        cmd_mode  = r.mode;
        cmd_delay = r.delay;
        cmd_len   = r.len;
        abort     = r.abort;
        sig_in    = r.sin;
    endtask

    initial begin
        reset = 1'b1; s_reset = 1'b1;
        cmd_valid = 0; cmd_mask = 0; cmd_mode = 0; cmd_delay = 0; cmd_len = 0; abort = 0; sig_in = 0;
        s_valid = 0; s_mask = 0; s_mode = 0; s_delay = 0; s_len = 0; s_abort = 0; s_in = 0;
        repeat (2) tick();
        reset = 1'b0; s_reset = 1'b0;

        // Reset state with passthrough
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b101, 3'b101, 1, 0, 0, 0, 0);
        // Stuck-at-0 on bit 0, no delay, three cycles
        addRow(1, 3'b001, 2'b00, 0, 3, 0, 3'b111, 3'b111, 1, 0, 0, 0, 0);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b110, 0, 1, 0, 0, 0);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b110, 0, 1, 0, 0, 0);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b110, 0, 1, 0, 0, 0);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 0, 0, 1, 0, 0);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0, 1);
        // Flip bits 2:1 after delay 5 for 2 cycles; a held command waits until ready
        addRow(1, 3'b110, 2'b10, 5, 2, 0, 3'b000, 3'b000, 1, 0, 0, 0, 1);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b101, 3'b101, 0, 0, 0, 0, 1);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b010, 3'b010, 0, 0, 0, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b101, 3'b101, 0, 0, 0, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b010, 3'b010, 0, 0, 0, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b101, 3'b101, 0, 0, 0, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b010, 3'b100, 0, 1, 0, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b101, 3'b011, 0, 1, 0, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b010, 3'b010, 0, 0, 1, 0, 1);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b101, 3'b101, 1, 0, 0, 0, 2);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b000, 0, 1, 0, 0, 2);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 0, 0, 1, 0, 2);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0, 3);
        // Reserved mode: err pulse, stay idle
        addRow(1, 3'b111, 2'b11, 0, 1, 0, 3'b111, 3'b111, 1, 0, 0, 0, 3);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 1, 0, 0, 1, 3);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0, 3);
        // Abort beats a simultaneous command; accepted once abort drops
        addRow(1, 3'b111, 2'b00, 0, 1, 1, 3'b111, 3'b111, 0, 0, 0, 0, 3);
        addRow(1, 3'b111, 2'b00, 0, 1, 0, 3'b111, 3'b111, 1, 0, 0, 0, 3);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b000, 0, 1, 0, 0, 3);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 0, 0, 1, 0, 3);
        addRow(0, 3'b000, 2'b00, 0, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0, 4);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d sig_out", i), 32'(sig_out), 32'(vecs[i].eout));
            checkOutput($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].erdy));
            checkOutput($sformatf("row%0d inject_active", i), 32'(inject_active), 32'(vecs[i].eact));
            checkOutput($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].edone));
            checkOutput($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].eerr));
            checkOutput($sformatf("row%0d inj_count", i), 32'(inj_count), 32'(vecs[i].ecnt));
            tick();
        end

        // Unbounded stuck-at-1 window ended by abort in cycle 20
        cmd_valid = 1; cmd_mask = 3'b111; cmd_mode = 2'b01; cmd_delay = 0; cmd_len = 0;
        abort = 0; sig_in = 3'b000;
        #1 checkOutput("len0 accept ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 0;
        for (int c = 1; c < 20; c++) begin
            sig_in = 3'($urandom_range(0, 7));
            #1;
            checkOutput($sformatf("len0 c%0d sig_out", c), 32'(sig_out), 32'b111);
            checkOutput($sformatf("len0 c%0d active", c), 32'(inject_active), 32'd1);
            tick();
        end
        abort = 1; sig_in = 3'b000;
        #1 checkOutput("abort cycle sig_out", 32'(sig_out), 32'b111);
        checkOutput("abort cycle ready", 32'(cmd_ready), 32'd0);
        tick();
        abort = 0; sig_in = 3'b010;
        #1 checkOutput("post abort sig_out", 32'(sig_out), 32'b010);
        checkOutput("post abort active", 32'(inject_active), 32'd0);
        checkOutput("post abort ready", 32'(cmd_ready), 32'd1);
        checkOutput("post abort done", 32'(done), 32'd0);
        tick();
        checkOutput("post abort done2", 32'(done), 32'd0);
        checkOutput("post abort count", 32'(inj_count), 32'd4);

        // Reset while in WAIT
        cmd_valid = 1; cmd_mask = 3'b111; cmd_mode = 2'b00; cmd_delay = 10; cmd_len = 1;
        tick();
        cmd_valid = 0;
        checkOutput("wait ready", 32'(cmd_ready), 32'd0);
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0; sig_in = 3'b111;
        #1 checkOutput("reset in wait ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset in wait count", 32'(inj_count), 32'd0);
        checkOutput("reset in wait sig_out", 32'(sig_out), 32'b111);
        for (int c = 0; c < 12; c++) begin
            tick();
            checkOutput($sformatf("after reset c%0d active", c), 32'(inject_active), 32'd0);
            checkOutput($sformatf("after reset c%0d done", c), 32'(done), 32'd0);
        end

        // Saturating completion count on a 2-bit counter
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1; s_mask = 3'b001; s_mode = 2'b10; s_delay = 0; s_len = 1; s_in = 3'b000;
            #1 checkOutput($sformatf("sat w%0d ready", k), 32'(s_ready), 32'd1);
            tick();
            s_valid = 0;
            checkOutput($sformatf("sat w%0d sig_out", k), 32'(s_out), 32'b001);
            tick();
            checkOutput($sformatf("sat w%0d done", k), 32'(s_done), 32'd1);
            tick();
            checkOutput($sformatf("sat w%0d count", k), 32'(s_count), (k > 3) ? 32'd3 : 32'(k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
